// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem read, presents a single fetched
// instruction to decode, and handles stall, redirect and stale-response draining.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h01000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] PC_f,
   output logic [31:0] inst_f,
   output logic        valid_f,
   output logic [1:0]  state_o
);

   localparam logic [1:0] S_REQ   = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_HAVE  = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;
   localparam logic [31:0] NOP    = 32'h00000013;

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pc_f_q, pc_f_d;
   logic [31:0] inst_q, inst_d;
   logic        valid_q, valid_d;
   logic        req_c;
   logic [31:0] addr_c;
   logic [31:0] pc_inc;
   logic [31:0] redir_tgt;

   assign pc_inc    = pc_q + 32'd4;
   assign redir_tgt = {redirect_pc[31:2], 2'b00};

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      pc_f_d  = pc_f_q;
      inst_d  = inst_q;
      valid_d = valid_q;
      req_c   = 1'b0;
      addr_c  = pc_q;
      case (state_q)
         S_REQ: begin
            if (redirect_valid) begin
               pc_d    = redir_tgt;
               valid_d = 1'b0;
               pc_f_d  = 32'h0;
               inst_d  = NOP;
            end else begin
               req_c   = 1'b1;
               addr_c  = pc_q;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (redirect_valid) begin
               pc_d    = redir_tgt;
               valid_d = 1'b0;
               pc_f_d  = 32'h0;
               inst_d  = NOP;
               state_d = imem_rvalid ? S_REQ : S_DRAIN;
            end else if (imem_rvalid) begin
               inst_d  = imem_rdata;
               pc_f_d  = pc_q;
               valid_d = 1'b1;
               state_d = S_HAVE;
            end
         end
         S_HAVE: begin
            if (redirect_valid) begin
               pc_d    = redir_tgt;
               valid_d = 1'b0;
               pc_f_d  = 32'h0;
               inst_d  = NOP;
               state_d = S_REQ;
            end else if (!stall) begin
               req_c   = 1'b1;
               addr_c  = pc_inc;
               pc_d    = pc_inc;
               valid_d = 1'b0;
               pc_f_d  = 32'h0;
               inst_d  = NOP;
               state_d = S_WAIT;
            end
         end
         S_DRAIN: begin
            // A redirect here only retargets pc; the stale response must still
            // be consumed, otherwise nothing would ever leave DRAIN.
            if (redirect_valid) pc_d = redir_tgt;
            if (imem_rvalid) state_d = S_REQ;
         end
         default: state_d = S_REQ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_REQ;
         pc_q    <= RESET_PC;
         pc_f_q  <= 32'h0;
         inst_q  <= NOP;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pc_f_q  <= pc_f_d;
         inst_q  <= inst_d;
         valid_q <= valid_d;
      end
   end

   assign imem_req  = req_c & ~reset;
   assign imem_addr = addr_c;
   assign PC_f      = pc_f_q;
   assign inst_f    = inst_q;
   assign valid_f   = valid_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming fetch, stall hold, redirect drain,
// redirect-over-stall, pc wrap and reset during an outstanding request.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] PC_f;
   logic [31:0] inst_f;
   logic        valid_f;
   logic [1:0]  state_o;

   // Memory model: 1-cycle latency responder, or manual drive when auto_mem=0.
   logic        auto_mem;
   logic        pend_q;
   logic [31:0] pend_addr_q;
   logic        man_rvalid;
   logic [31:0] man_rdata;

   int vec_cnt = 0;
   int err_cnt = 0;

   localparam logic [31:0] KEY = 32'hA5A5A5A5;
   localparam logic [31:0] NOP = 32'h00000013;

   fetch_unit #(.RESET_PC(32'h01000000)) dut (
      .clk(clk), .reset(reset), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .PC_f(PC_f), .inst_f(inst_f), .valid_f(valid_f), .state_o(state_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      pend_q      <= imem_req;
      pend_addr_q <= imem_addr;
   end

   assign imem_rvalid = auto_mem ? pend_q : man_rvalid;
   assign imem_rdata  = auto_mem ? (pend_addr_q ^ KEY) : man_rdata;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_valid"}, {31'b0, valid_f}, 32'd0);
      check_eq({tag, "_inst"}, inst_f, NOP);
      check_eq({tag, "_pc"}, PC_f, 32'h0);
   endtask

   task automatic check_have(input string tag, input logic [31:0] pc, input logic [31:0] inst);
      check_eq({tag, "_valid"}, {31'b0, valid_f}, 32'd1);
      check_eq({tag, "_pc"}, PC_f, pc);
      check_eq({tag, "_inst"}, inst_f, inst);
   endtask

   task automatic check_req(input string tag, input logic [31:0] addr);
      check_eq({tag, "_req"}, {31'b0, imem_req}, 32'd1);
      check_eq({tag, "_addr"}, imem_addr, addr);
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
      auto_mem = 1'b1; man_rvalid = 1'b0; man_rdata = 32'h0;
      pend_q = 1'b0; pend_addr_q = 32'h0;

      // Reset state
      tick();
      tick();
      check_eq("rst_req", {31'b0, imem_req}, 32'd0);
      check_idle_outputs("rst");
      check_eq("rst_state", {30'b0, state_o}, 32'd0);
      reset = 1'b0;
      #1;

      // Streaming fetch, 1-cycle memory, valid every other cycle
      for (int k = 0; k < 3; k++) begin
         logic [31:0] a;
         a = 32'h01000000 + 32'(4 * k);
         check_req("stream_issue", a);
         tick();
         check_eq("stream_wait_req", {31'b0, imem_req}, 32'd0);
         check_idle_outputs("stream_wait");
         tick();
         check_have("stream_have", a, a ^ KEY);
      end

      // Stall for 3 cycles in HAVE
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         check_eq("stall_req", {31'b0, imem_req}, 32'd0);
         tick();
         check_have("stall_hold", 32'h01000008, 32'h01000008 ^ KEY);
      end
      stall = 1'b0;
      #1;
      check_req("stall_release", PC_f + 32'd4);
      tick();
      tick();
      check_have("post_stall", 32'h0100000C, 32'h0100000C ^ KEY);

      // Redirect in WAIT, response arrives two cycles later and is dropped
      auto_mem = 1'b0;
      tick();
      redirect_valid = 1'b1; redirect_pc = 32'h01000103;
      #1;
      check_eq("redir_wait_req", {31'b0, imem_req}, 32'd0);
      tick();
      redirect_valid = 1'b0;
      check_idle_outputs("drain1");
      check_eq("drain1_req", {31'b0, imem_req}, 32'd0);
      tick();
      man_rvalid = 1'b1; man_rdata = 32'hDEADBEEF;
      #1;
      check_eq("drain2_req", {31'b0, imem_req}, 32'd0);
      tick();
      man_rvalid = 1'b0;
      #1;
      check_idle_outputs("drained");
      check_req("redir_target", 32'h01000100);
      auto_mem = 1'b1;
      tick();
      tick();
      check_have("redir_have", 32'h01000100, 32'h01000100 ^ KEY);

      // Redirect and stall together in HAVE
      redirect_valid = 1'b1; redirect_pc = 32'h02000000; stall = 1'b1;
      #1;
      check_eq("rs_req", {31'b0, imem_req}, 32'd0);
      tick();
      redirect_valid = 1'b0; stall = 1'b0;
      #1;
      check_idle_outputs("rs");
      check_req("rs_target", 32'h02000000);
      tick();
      tick();
      check_have("rs_have", 32'h02000000, 32'h02000000 ^ KEY);

      // pc wraps from FFFFFFFC to 0
      redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFFC;
      tick();
      redirect_valid = 1'b0;
      #1;
      check_req("wrap_issue", 32'hFFFFFFFC);
      tick();
      tick();
      check_have("wrap_top", 32'hFFFFFFFC, 32'h5A5A5A59);
      check_req("wrap_next", 32'h00000000);
      tick();
      tick();
      check_have("wrap_zero", 32'h00000000, KEY);

      // Reset mid-WAIT, stray response ignored
      auto_mem = 1'b0;
      tick();
      reset = 1'b1;
      #1;
      check_eq("rst_wait_req", {31'b0, imem_req}, 32'd0);
      tick();
      reset = 1'b0;
      man_rvalid = 1'b1; man_rdata = 32'h12345678;
      #1;
      check_idle_outputs("rst_stray");
      check_req("rst_first", 32'h01000000);
      tick();
      man_rvalid = 1'b0;
      #1;
      check_idle_outputs("rst_after_stray");
      man_rvalid = 1'b1; man_rdata = 32'h0BADF00D;
      tick();
      man_rvalid = 1'b0;
      check_have("rst_have", 32'h01000000, 32'h0BADF00D);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h01000000, giving the first fetch address after reset.
REQ-002 SHALL have a single clock domain; reset is synchronous and active-high.
REQ-003 SHALL have port clk, input, 1, the clock, rising-edge active.
REQ-004 SHALL have port reset, input, 1, the synchronous active-high reset.
REQ-005 SHALL have port stall, input, 1, which holds the presented instruction because decode is not accepting.
REQ-006 SHALL have port redirect_valid, input, 1, which signals a taken branch or jump from execute.
REQ-007 SHALL have port redirect_pc, input, 32, the redirect target.
REQ-008 SHALL have port imem_req, output, 1, a one-cycle instruction-memory read request.
REQ-009 SHALL have port imem_addr, output, 32, the read address, valid while imem_req=1.
REQ-010 SHALL have port imem_rvalid, input, 1, which marks a read response.
REQ-011 SHALL have port imem_rdata, input, 32, the response instruction word.
REQ-012 SHALL have port PC_f, output, 32, the PC of the presented instruction.
REQ-013 SHALL have port inst_f, output, 32, the presented instruction.
REQ-014 SHALL have port valid_f, output, 1, which is 1 when PC_f/inst_f hold a real fetched instruction.

Function
REQ-015 SHALL use FSM states REQ (issue request), WAIT (await response), HAVE (instruction presented) and DRAIN (discard stale response).
REQ-016 SHALL accept every request unconditionally at the memory; latency is >=1 cycle, with at most one request outstanding.
REQ-017 SHALL keep an internal 32-bit pc register; all increments are pc+4 modulo 2^32, so 32'hFFFFFFFC wraps to 0.
REQ-018 In REQ without redirect, SHALL drive imem_req=1 with imem_addr=pc and go to WAIT.
REQ-019 In WAIT, on imem_rvalid=1, SHALL register inst_f<=imem_rdata, PC_f<=pc and valid_f<=1, then go to HAVE.
REQ-020 In WAIT, SHALL leave outputs unchanged until imem_rvalid arrives.
REQ-021 In HAVE with stall=1, SHALL hold PC_f, inst_f and valid_f unchanged, issue no request, and remain in HAVE.
REQ-022 In HAVE with stall=0 and no redirect, SHALL drive imem_req=1 with imem_addr=pc+4 in the same cycle, set pc<=pc+4 and valid_f<=0, and go to WAIT.
REQ-023 Steady-state throughput with 1-cycle latency and no stalls SHALL be one instruction per 2 cycles.
REQ-024 Whenever valid_f=0, SHALL present inst_f=32'h13 (NOP) and PC_f=32'h0.
REQ-025 Redirect SHALL take priority over stall and over imem_rvalid in the same cycle.
REQ-026 On a redirect, SHALL set pc<=redirect_pc with bits [1:0] forced to 0 and valid_f<=0.
REQ-027 On a redirect, SHALL drive imem_req=0 in the redirect cycle.
REQ-028 On a redirect in REQ or HAVE, SHALL go to REQ next.
REQ-029 On a redirect in WAIT with imem_rvalid=0, SHALL go to DRAIN.
REQ-030 On a redirect in WAIT with imem_rvalid=1, SHALL discard that response and go to REQ.
REQ-031 In DRAIN, on imem_rvalid=1, SHALL discard the data and go to REQ; outputs are unchanged.
REQ-032 In DRAIN, a further redirect SHALL update pc only and the FSM SHALL stay in DRAIN.
REQ-033 Outside WAIT and DRAIN, imem_rvalid SHALL be ignored.
REQ-034 imem_req SHALL never assert in WAIT or DRAIN.

Reset
REQ-035 When reset=1 at a rising edge, SHALL load pc<=RESET_PC, state<=REQ, valid_f<=0, PC_f<=0 and inst_f<=32'h13.
REQ-036 imem_req SHALL be 0 during any cycle in which reset=1.
REQ-037 Reset SHALL override redirect, stall and imem_rvalid.
REQ-038 Reset asserted mid-WAIT or mid-DRAIN SHALL abandon the outstanding request, and any response arriving in REQ after reset SHALL be ignored.

Verification
REQ-039 Bench SHALL check: reset, then memory with 1-cycle latency returning pc^32'hA5A5A5A5 and stall=0 -> imem_addr sequence 01000000, 01000004, 01000008; each inst_f presented with matching PC_f; valid_f high every other cycle.
REQ-040 Bench SHALL check: stall=1 for 3 cycles while in HAVE -> PC_f, inst_f and valid_f constant, imem_req=0 throughout; after release, next imem_addr = PC_f+4.
REQ-041 Bench SHALL check: redirect_valid=1 with redirect_pc=32'h01000103 while in WAIT, response arriving 2 cycles later -> response dropped, valid_f stays 0, next imem_addr=32'h01000100.
REQ-042 Bench SHALL check: redirect and stall both 1 in HAVE -> valid_f=0, inst_f=32'h13, PC_f=0 next cycle, then request to the redirect target.
REQ-043 Bench SHALL check: pc=32'hFFFFFFFC with stall=0 -> next imem_addr=32'h00000000.
REQ-044 Bench SHALL check: reset pulsed while in WAIT, then a stray imem_rvalid -> outputs stay at reset values, and the first request after reset targets RESET_PC.
